// File: rtl/imem_program_loader.sv
// -----------------------------------------------------------------------------
// imem_program_loader
//
// Loads a program from a host byte stream into the instruction memory of the
// RV32I core and keeps the core in reset until the load has succeeded.
//
// Stream format: 2-byte little-endian word count LEN, then LEN words of 4 bytes.
// Each word arrives little-endian (byte0 -> [7:0] ... byte3 -> [31:24]).
// Word i is written to IMEM word address i.
//
// Ports
//   clk         system clock, all logic on posedge
//   reset       synchronous, active-high
//   start       1-cycle pulse, begins a (re)load from IDLE / DONE / ERR
//   in_valid    host byte valid
//   in_data     host byte
//   in_ready    loader accepts a byte this cycle (combinational from state)
//   imem_we     IMEM write strobe, one cycle per word
//   imem_addr   IMEM word address
//   imem_wdata  IMEM write data
//   cpu_reset   core reset; low only after a successful load
//   busy        header or data phase in progress
//   done        level, load completed
//   error       level, bad header (LEN == 0 or LEN > 2**ADDR_W)
// -----------------------------------------------------------------------------
module imem_program_loader #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_reset,
  output logic              busy,
  output logic              done,
  output logic              error
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_DATA,
    S_DONE,
    S_ERR
  } state_t;

  // Largest legal LEN; 17 bits so that ADDR_W = 16 still fits.
  localparam logic [16:0] MAX_LEN = 17'(1) << ADDR_W;

  state_t            state;
  state_t            next_state;
  logic [1:0]        byte_cnt;
  logic [7:0]        len_lo;
  logic [15:0]       len;
  logic [ADDR_W:0]   word_idx;   // one extra bit so LEN = 2**ADDR_W is reachable
  logic [23:0]       partial;    // bytes 0..2 of the word being assembled
  logic              last_pend;  // final word's write is on the bus this cycle
  logic              accept;
  logic [15:0]       hdr_len;
  logic              len_bad;
  logic [16:0]       idx_next;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned; otherwise synthesis infers a latch.
    in_ready   = (state == S_HDR) || (state == S_DATA);
    accept     = in_valid && in_ready;
    hdr_len    = {in_data, len_lo};
    len_bad    = (hdr_len == 16'd0) || ({1'b0, hdr_len} > MAX_LEN);
    idx_next   = 17'(word_idx) + 17'd1;
    next_state = state;
    case (state)
      S_IDLE, S_DONE, S_ERR: if (start) next_state = S_HDR;
      S_HDR:  if (accept && byte_cnt == 2'd1) next_state = len_bad ? S_ERR : S_DATA;
      // Leave DATA only after the last write cycle, so done follows that write.
      S_DATA: if (last_pend) next_state = S_DONE;
      default: next_state = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= next_state;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      cpu_reset  <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
      byte_cnt   <= '0;
      len_lo     <= '0;
      len        <= '0;
      word_idx   <= '0;
      partial    <= '0;
      last_pend  <= 1'b0;
    end else begin
      // Flags are decoded from the upcoming state so they change on the same
      // edge as the state (e.g. start in DONE re-asserts cpu_reset at once).
      imem_we   <= 1'b0;
      cpu_reset <= (next_state != S_DONE);
      busy      <= (next_state == S_HDR) || (next_state == S_DATA);
      done      <= (next_state == S_DONE);
      error     <= (next_state == S_ERR);

      case (state)
        S_HDR: begin
          if (accept) begin
            if (byte_cnt == 2'd0) begin
              len_lo   <= in_data;
              byte_cnt <= 2'd1;
            end else begin
              len      <= hdr_len;
              byte_cnt <= 2'd0;
            end
          end
        end
        S_DATA: begin
          // Bytes offered while the final write is pending are not part of the load.
          if (accept && !last_pend) begin
            byte_cnt <= byte_cnt + 2'd1;
            case (byte_cnt)
              2'd0: partial[7:0]   <= in_data;
              2'd1: partial[15:8]  <= in_data;
              2'd2: partial[23:16] <= in_data;
              default: begin
                imem_we    <= 1'b1;
                imem_addr  <= word_idx[ADDR_W-1:0];
                imem_wdata <= {in_data, partial};
                word_idx   <= idx_next[ADDR_W:0];
                if (idx_next == {1'b0, len}) last_pend <= 1'b1;
              end
            endcase
          end
        end
        default: begin
          // IDLE / DONE / ERR: start every load from a clean slate.
          byte_cnt  <= '0;
          len_lo    <= '0;
          len       <= '0;
          word_idx  <= '0;
          partial   <= '0;
          last_pend <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_program_loader.sv
// -----------------------------------------------------------------------------
// tb_imem_program_loader
//
// Two loader instances share one byte bus: d=0 has ADDR_W=8, d=1 has ADDR_W=2.
// Each has its own start and reset; an idle instance has in_ready=0 and so
// ignores bytes meant for the other. Inputs change and outputs are sampled on
// the falling edge. Expected writes come from the word buffer wbuf, and header
// legality from the rule 1 <= LEN <= 2**ADDR_W.
// -----------------------------------------------------------------------------
module tb_imem_program_loader;

  logic        clk = 1'b0;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        start_v [2];
  logic        rst_v   [2];
  logic        rdy_v   [2];
  logic        we_v    [2];
  logic        cr_v    [2];
  logic        busy_v  [2];
  logic        done_v  [2];
  logic        err_v   [2];
  logic [31:0] wd_v    [2];
  logic [7:0]  addr8;
  logic [1:0]  addr2;

  int          n_cmp  = 0;
  int          n_fail = 0;
  int          wr_cnt [2];
  logic [31:0] wbuf   [300];

  always #5 clk = ~clk;

  imem_program_loader #(.ADDR_W(8)) dut8 (
    .clk(clk), .reset(rst_v[0]), .start(start_v[0]),
    .in_valid(in_valid), .in_data(in_data), .in_ready(rdy_v[0]),
    .imem_we(we_v[0]), .imem_addr(addr8), .imem_wdata(wd_v[0]),
    .cpu_reset(cr_v[0]), .busy(busy_v[0]), .done(done_v[0]), .error(err_v[0])
  );

  imem_program_loader #(.ADDR_W(2)) dut2 (
    .clk(clk), .reset(rst_v[1]), .start(start_v[1]),
    .in_valid(in_valid), .in_data(in_data), .in_ready(rdy_v[1]),
    .imem_we(we_v[1]), .imem_addr(addr2), .imem_wdata(wd_v[1]),
    .cpu_reset(cr_v[1]), .busy(busy_v[1]), .done(done_v[1]), .error(err_v[1])
  );

  // Counts every write strobe so stray writes are caught.
  always @(negedge clk) begin
    if (we_v[0]) wr_cnt[0]++;
    if (we_v[1]) wr_cnt[1]++;
  end

  function automatic logic [7:0] addr_of(input int d);
    return (d == 0) ? addr8 : {6'b0, addr2};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Offers byte b after `gap` idle cycles; returns one cycle after acceptance.
  task automatic send_byte(input int d, input logic [7:0] b, input int gap);
    int t;
    repeat (gap) tick();
    in_valid = 1'b1;
    in_data  = b;
    t = 0;
    while (!rdy_v[d] && t < 20) begin
      tick();
      t++;
    end
    check("byte_ready", 64'(rdy_v[d]), 64'd1);
    tick();
    in_valid = 1'b0;
  endtask

  // start pulse: next cycle must show {busy,cpu_reset,done,error,in_ready}=11001.
  task automatic pulse_start(input int d);
    start_v[d] = 1'b1;
    tick();
    start_v[d] = 1'b0;
    check("after_start", {busy_v[d], cr_v[d], done_v[d], err_v[d], rdy_v[d]}, 64'b11001);
  endtask

  // Full load of `len` words from wbuf; random valid gaps up to gap_max cycles.
  task automatic do_load(input int d, input int len, input int max_len, input int gap_max);
    int base;
    base = wr_cnt[d];
    pulse_start(d);
    send_byte(d, 8'(len), 0);
    send_byte(d, 8'(len >> 8), $urandom_range(gap_max, 0));
    if (len == 0 || len > max_len) begin
      check("hdr_err", {err_v[d], rdy_v[d], cr_v[d], busy_v[d], done_v[d], we_v[d]}, 64'b101000);
      repeat (3) tick();
      check("err_no_write", 64'(wr_cnt[d]), 64'(base));
      check("err_hold", {err_v[d], cr_v[d], rdy_v[d]}, 64'b110);
    end else begin
      for (int i = 0; i < len; i++) begin
        for (int b = 0; b < 4; b++)
          send_byte(d, wbuf[i][8*b +: 8], $urandom_range(gap_max, 0));
        check("write", {we_v[d], addr_of(d), wd_v[d], done_v[d]},
              {1'b1, 8'(i), wbuf[i], 1'b0});
      end
      tick();
      check("done", {done_v[d], cr_v[d], err_v[d], busy_v[d], we_v[d], rdy_v[d]}, 64'b100000);
      repeat (2) tick();
      check("write_count", 64'(wr_cnt[d]), 64'(base + len));
    end
  endtask

  initial begin
    int base;
    in_valid   = 1'b0;
    in_data    = 8'h00;
    wr_cnt[0]  = 0;
    wr_cnt[1]  = 0;
    start_v[0] = 1'b0;
    start_v[1] = 1'b0;
    rst_v[0]   = 1'b1;
    rst_v[1]   = 1'b1;
    repeat (3) tick();
    rst_v[0] = 1'b0;
    rst_v[1] = 1'b0;

    // Idle after reset.
    for (int c = 0; c < 10; c++) begin
      check("idle8", {cr_v[0], rdy_v[0], we_v[0], done_v[0], err_v[0], busy_v[0]}, 64'b100000);
      check("idle2", {cr_v[1], rdy_v[1], we_v[1], done_v[1], err_v[1], busy_v[1]}, 64'b100000);
      tick();
    end

    // Two-instruction program, back-to-back bytes.
    wbuf[0] = 32'h00100513;
    wbuf[1] = 32'h00200593;
    do_load(0, 2, 256, 0);

    // Header 00 00, then recovery with a 1-word load.
    do_load(0, 0, 256, 0);
    wbuf[0] = $urandom;
    do_load(0, 1, 256, 1);

    // Header with nonzero high byte exceeding capacity.
    do_load(0, 257, 256, 0);

    // ADDR_W=2: LEN 5 rejected, LEN 4 fills memory exactly.
    do_load(1, 5, 4, 0);
    for (int i = 0; i < 4; i++) wbuf[i] = $urandom;
    do_load(1, 4, 4, 2);
    check("other_idle", 64'(wr_cnt[0] > 0 && busy_v[0] == 1'b0), 64'd1);

    // Pause of 5 cycles after two bytes of word0.
    wbuf[0] = $urandom;
    base = wr_cnt[0];
    pulse_start(0);
    send_byte(0, 8'h01, 0);
    send_byte(0, 8'h00, 0);
    send_byte(0, wbuf[0][7:0], 0);
    send_byte(0, wbuf[0][15:8], 0);
    repeat (5) begin
      check("pause_hold", {we_v[0], busy_v[0], rdy_v[0], done_v[0]}, 64'b0110);
      tick();
    end
    send_byte(0, wbuf[0][23:16], 0);
    send_byte(0, wbuf[0][31:24], 0);
    check("pause_write", {we_v[0], addr8, wd_v[0]}, {1'b1, 8'd0, wbuf[0]});
    tick();
    check("pause_done", {done_v[0], cr_v[0]}, 64'b10);
    repeat (2) tick();
    check("pause_count", 64'(wr_cnt[0]), 64'(base + 1));

    // Reset after two data bytes: partial word dropped.
    base = wr_cnt[0];
    pulse_start(0);
    send_byte(0, 8'h01, 0);
    send_byte(0, 8'h00, 0);
    send_byte(0, 8'hAA, 0);
    send_byte(0, 8'hBB, 0);
    rst_v[0] = 1'b1;
    tick();
    rst_v[0] = 1'b0;
    check("rst_state", {cr_v[0], busy_v[0], rdy_v[0], we_v[0], done_v[0], err_v[0]}, 64'b100000);
    repeat (3) tick();
    check("rst_no_write", 64'(wr_cnt[0]), 64'(base));
    check("rst_idle", {cr_v[0], rdy_v[0], busy_v[0]}, 64'b100);

    // Random loads, each restarting from DONE or IDLE.
    for (int k = 0; k < 4; k++) begin
      int n;
      n = $urandom_range(12, 1);
      for (int i = 0; i < n; i++) wbuf[i] = $urandom;
      do_load(0, n, 256, 3);
    end

    // LEN = 256 fills the 8-bit memory exactly, then reload from DONE.
    for (int i = 0; i < 256; i++) wbuf[i] = $urandom;
    do_load(0, 256, 256, 0);
    wbuf[0] = $urandom;
    wbuf[1] = $urandom;
    do_load(0, 2, 256, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
